// File: rtl/i2s_pkg.sv
// Shared constants for the I2S / left-justified receiver: FSM encoding,
// framing modes and word-select channel values.
package i2s_pkg;

  // Receiver FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_SKIP  = 2'd3;

  // Framing modes
  localparam int JUSTIFY_I2S  = 0;
  localparam int JUSTIFY_LEFT = 1;

  // Word-select channel values
  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_edge_sync.sv
// Brings the asynchronous serial-audio pins into the system clock domain.
// All three pins go through chains of equal depth, so ws_s/sd_s are the
// values that were present when the sck rising edge occurred.
module i2s_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sck,
  input  logic ws,
  input  logic sd,
  output logic sck_rise,
  output logic ws_s,
  output logic sd_s
);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic                   sck_prev_q, sck_prev_d;

  // Shift each pin one stage further down its synchroniser chain
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
    ws_sync_d  = {ws_sync_q[SYNC_STAGES-2:0], ws};
    sd_sync_d  = {sd_sync_q[SYNC_STAGES-2:0], sd};
    sck_prev_d = sck_sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and edge-detect registers
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      ws_sync_q  <= ws_sync_d;
      sd_sync_q  <= sd_sync_d;
      sck_prev_q <= sck_prev_d;
    end
  end

  assign sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign ws_s     = ws_sync_q[SYNC_STAGES-1];
  assign sd_s     = sd_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx_stream.sv
// Serial-audio receiver: frames I2S or left-justified slots, deserialises
// MSB-first samples and hands them out through a one-entry valid/ready register.
//
// state | meaning
// IDLE  | waiting for the first WS edge; partial slot discarded
// DELAY | I2S only: WS-edge bit belongs to the previous slot, capture MSB next
// SHIFT | capturing sample bits MSB first
// SKIP  | sample complete, ignoring slot padding until the next WS edge
//
// In I2S mode the bit sampled on a WS edge is the LSB of the slot that is
// ending, so a WS edge in SHIFT first shifts that bit in and then commits.
// In left-justified mode the WS-edge bit is the MSB of the new slot.
module i2s_rx_stream
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int JUSTIFY     = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sck,
  input  logic                  ws,
  input  logic                  sd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_right,
  output logic                  rx_short,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun
);

  localparam int             CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic sck_rise, ws_s, sd_s;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  ws_prev_q, ws_prev_d;
  logic                  chan_q, chan_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_right_q, rx_right_d;
  logic                  rx_short_q, rx_short_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d;

  logic                  ws_edge;
  logic [DATA_WIDTH-1:0] shift_in;
  logic [DATA_WIDTH-1:0] first_bit;
  logic [CW-1:0]         cnt_inc;
  logic [1:0]            start_state;
  logic [CW-1:0]         start_cnt;
  logic [DATA_WIDTH-1:0] start_shift;
  logic                  commit;
  logic                  commit_short;
  logic [DATA_WIDTH-1:0] commit_data;

  i2s_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset   (reset),
    .sck     (sck),
    .ws      (ws),
    .sd      (sd),
    .sck_rise(sck_rise),
    .ws_s    (ws_s),
    .sd_s    (sd_s)
  );

  // Slot framing FSM, shift register and bit counter
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    ws_prev_d    = ws_prev_q;
    chan_d       = chan_q;
    commit       = 1'b0;
    commit_short = 1'b0;
    commit_data  = '0;

    ws_edge   = (ws_s != ws_prev_q);
    shift_in  = {shift_q[DATA_WIDTH-2:0], sd_s};
    first_bit = {{(DATA_WIDTH-1){1'b0}}, sd_s};
    cnt_inc   = cnt_q + CNT_ONE;

    // Where a new slot begins depends on the framing mode
    if (JUSTIFY == JUSTIFY_LEFT) begin
      start_state = ST_SHIFT;
      start_cnt   = CNT_ONE;
      start_shift = first_bit;
    end else begin
      start_state = ST_DELAY;
      start_cnt   = '0;
      start_shift = '0;
    end

    if (sck_rise) begin
      ws_prev_d = ws_s;
      case (state_q)
        ST_IDLE: begin
          if (ws_edge) begin
            state_d = start_state;
            cnt_d   = start_cnt;
            shift_d = start_shift;
            chan_d  = ws_s;
          end
        end
        ST_DELAY: begin
          state_d = ST_SHIFT;
          cnt_d   = CNT_ONE;
          shift_d = first_bit;
        end
        ST_SHIFT: begin
          if (ws_edge && JUSTIFY == JUSTIFY_I2S) begin
            commit       = 1'b1;
            commit_data  = shift_in << (CNT_FULL - cnt_inc);
            commit_short = (cnt_inc != CNT_FULL);
            state_d      = start_state;
            cnt_d        = start_cnt;
            shift_d      = start_shift;
            chan_d       = ws_s;
          end else if (ws_edge) begin
            commit       = (cnt_q != '0);
            commit_data  = shift_q << (CNT_FULL - cnt_q);
            commit_short = 1'b1;
            state_d      = start_state;
            cnt_d        = start_cnt;
            shift_d      = start_shift;
            chan_d       = ws_s;
          end else begin
            shift_d = shift_in;
            cnt_d   = cnt_inc;
            if (cnt_inc == CNT_FULL) begin
              commit      = 1'b1;
              commit_data = shift_in;
              state_d     = ST_SKIP;
            end
          end
        end
        default: begin
          if (ws_edge) begin
            state_d = start_state;
            cnt_d   = start_cnt;
            shift_d = start_shift;
            chan_d  = ws_s;
          end
        end
      endcase
    end

    // Disabled receiver drops any partial slot; ws_prev keeps tracking so a
    // re-enable resynchronises on a genuine WS edge.
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      shift_d = '0;
      commit  = 1'b0;
    end
  end

  // One-entry output register with overrun detection
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_right_d = rx_right_q;
    rx_short_d = rx_short_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (commit) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = commit_data;
        rx_right_d = (chan_q == WS_RIGHT);
        rx_short_d = commit_short;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ws_prev_q  <= WS_LEFT;
      chan_q     <= WS_LEFT;
      rx_data_q  <= '0;
      rx_right_q <= 1'b0;
      rx_short_q <= 1'b0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ws_prev_q  <= ws_prev_d;
      chan_q     <= chan_d;
      rx_data_q  <= rx_data_d;
      rx_right_q <= rx_right_d;
      rx_short_q <= rx_short_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_right = rx_right_q;
  assign rx_short = rx_short_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_i2s_rx_stream.sv
// Bench for i2s_rx_stream: an I2S receiver (24-bit) and a left-justified
// receiver (16-bit) share the serial lines; only one is enabled at a time.
module tb_i2s_rx_stream;

  typedef struct {
    logic [31:0] data;
    logic        right;
    logic        shrt;
  } exp_t;

  typedef struct {
    bit          dut_b;
    int          slot;
    int          wbits;
    logic [31:0] lw;
    logic [31:0] rw;
    logic [31:0] el;
    logic [31:0] er;
    bit          shrt;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_a, enable_b;
  logic        sck, ws, sd;
  logic        rx_ready_a, rx_ready_b;
  logic [23:0] rx_data_a;
  logic [15:0] rx_data_b;
  logic        rx_right_a, rx_short_a, rx_valid_a, overrun_a;
  logic        rx_right_b, rx_short_b, rx_valid_b, overrun_b;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   ovr_a  = 0;
  int   ovr_b  = 0;
  int   ovr0;
  exp_t q_a[$];
  exp_t q_b[$];
  bit   ws_l[$];
  bit   sd_l[$];
  vec_t vecs[7];

  always #5 clock = ~clock;

  i2s_rx_stream #(.DATA_WIDTH(24), .JUSTIFY(0), .SYNC_STAGES(2)) dut_a (
    .clock(clock), .reset(reset), .enable(enable_a),
    .sck(sck), .ws(ws), .sd(sd),
    .rx_data(rx_data_a), .rx_right(rx_right_a), .rx_short(rx_short_a),
    .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .overrun(overrun_a)
  );

  i2s_rx_stream #(.DATA_WIDTH(16), .JUSTIFY(1), .SYNC_STAGES(2)) dut_b (
    .clock(clock), .reset(reset), .enable(enable_b),
    .sck(sck), .ws(ws), .sd(sd),
    .rx_data(rx_data_b), .rx_right(rx_right_b), .rx_short(rx_short_b),
    .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .overrun(overrun_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard for receiver A: every handshake pops one expected word
  always @(negedge clock) begin
    exp_t e;
    if (!reset && rx_valid_a && rx_ready_a) begin
      if (q_a.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_a: got 0x%0h expected no output", rx_data_a);
      end else begin
        e = q_a.pop_front();
        chk("data_a", 32'(rx_data_a), e.data);
        chk("right_a", 32'(rx_right_a), 32'(e.right));
        chk("short_a", 32'(rx_short_a), 32'(e.shrt));
      end
    end
    if (overrun_a) ovr_a++;
  end

  // Scoreboard for receiver B
  always @(negedge clock) begin
    exp_t e;
    if (!reset && rx_valid_b && rx_ready_b) begin
      if (q_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_b: got 0x%0h expected no output", rx_data_b);
      end else begin
        e = q_b.pop_front();
        chk("data_b", 32'(rx_data_b), e.data);
        chk("right_b", 32'(rx_right_b), 32'(e.right));
        chk("short_b", 32'(rx_short_b), 32'(e.shrt));
      end
    end
    if (overrun_b) ovr_b++;
  end

  // Append one slot in left-justified form: word MSB first, then zero padding
  task automatic add_slot(input int bits, input logic [31:0] word, input int wbits, input bit w);
    for (int i = 0; i < bits; i++) begin
      ws_l.push_back(w);
      if (i < wbits) sd_l.push_back(word[wbits-1-i]);
      else           sd_l.push_back(1'b0);
    end
  endtask

  // Play the built bit list; I2S framing delays sd by one bit period.
  // At period ready_at, rx_ready_a rises exactly in the commit cycle.
  task automatic play(input bit i2s, input int ready_at, input logic [31:0] ready_exp);
    for (int i = 0; i < ws_l.size(); i++) begin
      ws = ws_l[i];
      if (!i2s)        sd = sd_l[i];
      else if (i == 0) sd = 1'b0;
      else             sd = sd_l[i-1];
      sck = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      sck = 1'b1;
      if (i == ready_at) begin
        repeat (2) @(posedge clock);
        #1;
        rx_ready_a = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("valid_stays", 32'(rx_valid_a), 32'd1);
        chk("reload_data", 32'(rx_data_a), ready_exp);
        @(posedge clock);
        #1;
      end else begin
        repeat (4) @(posedge clock);
        #1;
      end
    end
    ws_l.delete();
    sd_l.delete();
  endtask

  // Disable both receivers and park WS high so the next left slot is an edge
  task automatic idle();
    enable_a   = 1'b0;
    enable_b   = 1'b0;
    rx_ready_a = 1'b1;
    add_slot(3, 32'h0, 0, 1'b1);
    play(1'b0, -1, 32'h0);
  endtask

  task automatic drain();
    repeat (40) @(posedge clock);
    @(negedge clock);
    chk("drain_a", 32'(q_a.size()), 32'd0);
    chk("drain_b", 32'(q_b.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{dut_b:0, slot:32, wbits:24, lw:32'hA5A5A5, rw:32'h5A5A5A, el:32'hA5A5A5, er:32'h5A5A5A, shrt:0};
    vecs[1] = '{dut_b:1, slot:16, wbits:16, lw:32'h8001,   rw:32'h7FFE,   el:32'h8001,   er:32'h7FFE,   shrt:0};
    vecs[2] = '{dut_b:0, slot:16, wbits:16, lw:32'hBEEF,   rw:32'hCAFE,   el:32'hBEEF00, er:32'hCAFE00, shrt:1};
    vecs[3] = '{dut_b:0, slot:24, wbits:24, lw:32'h000001, rw:32'hFFFFFF, el:32'h000001, er:32'hFFFFFF, shrt:0};
    vecs[4] = '{dut_b:1, slot:32, wbits:16, lw:32'h1234,   rw:32'hFFFF,   el:32'h1234,   er:32'hFFFF,   shrt:0};
    vecs[5] = '{dut_b:1, slot:8,  wbits:8,  lw:32'hA5,     rw:32'h3C,     el:32'hA500,   er:32'h3C00,   shrt:1};
    vecs[6] = '{dut_b:0, slot:12, wbits:12, lw:32'hABC,    rw:32'h123,    el:32'hABC000, er:32'h123000, shrt:1};

    enable_a = 1'b0; enable_b = 1'b0;
    sck = 1'b0; ws = 1'b0; sd = 1'b0;
    rx_ready_a = 1'b1; rx_ready_b = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_valid_a", 32'(rx_valid_a), 32'd0);
    chk("rst_data_a", 32'(rx_data_a), 32'd0);
    chk("rst_right_a", 32'(rx_right_a), 32'd0);
    chk("rst_short_a", 32'(rx_short_a), 32'd0);
    chk("rst_ovr_a", 32'(overrun_a), 32'd0);
    chk("rst_valid_b", 32'(rx_valid_b), 32'd0);
    chk("rst_data_b", 32'(rx_data_b), 32'd0);

    // Table-driven frames: one left and one right sample each
    for (int v = 0; v < 7; v++) begin
      idle();
      if (vecs[v].dut_b) begin
        enable_b = 1'b1;
        q_b.push_back('{data:vecs[v].el, right:1'b0, shrt:vecs[v].shrt});
        q_b.push_back('{data:vecs[v].er, right:1'b1, shrt:vecs[v].shrt});
      end else begin
        enable_a = 1'b1;
        q_a.push_back('{data:vecs[v].el, right:1'b0, shrt:vecs[v].shrt});
        q_a.push_back('{data:vecs[v].er, right:1'b1, shrt:vecs[v].shrt});
      end
      add_slot(vecs[v].slot, vecs[v].lw, vecs[v].wbits, 1'b0);
      add_slot(vecs[v].slot, vecs[v].rw, vecs[v].wbits, 1'b1);
      add_slot(2, 32'h0, 0, 1'b0);
      play(!vecs[v].dut_b, -1, 32'h0);
      drain();
    end
    chk("no_ovr_table_a", 32'(ovr_a), 32'd0);
    chk("no_ovr_table_b", 32'(ovr_b), 32'd0);

    // Backpressure: second sample dropped, third loads in the handshake cycle
    idle();
    enable_a   = 1'b1;
    rx_ready_a = 1'b0;
    ovr0 = ovr_a;
    q_a.push_back('{data:32'h111111, right:1'b0, shrt:1'b0});
    q_a.push_back('{data:32'h333333, right:1'b0, shrt:1'b0});
    add_slot(32, 32'h111111, 24, 1'b0);
    add_slot(32, 32'h222222, 24, 1'b1);
    add_slot(32, 32'h333333, 24, 1'b0);
    add_slot(2, 32'h0, 0, 1'b1);
    play(1'b1, 88, 32'h333333);
    drain();
    chk("overrun_once", 32'(ovr_a - ovr0), 32'd1);

    // Enable dropped mid-slot: partial slot discarded, next full slot received
    idle();
    enable_a = 1'b1;
    q_a.push_back('{data:32'h123456, right:1'b1, shrt:1'b0});
    add_slot(10, 32'h654321, 24, 1'b0);
    play(1'b1, -1, 32'h0);
    enable_a = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("dis_no_valid", 32'(rx_valid_a), 32'd0);
    enable_a = 1'b1;
    add_slot(22, 32'h0, 0, 1'b0);
    add_slot(32, 32'h123456, 24, 1'b1);
    add_slot(2, 32'h0, 0, 1'b0);
    play(1'b1, -1, 32'h0);
    drain();

    // Reset mid-SHIFT with a word pending: everything cleared, capture resumes
    idle();
    enable_a   = 1'b1;
    rx_ready_a = 1'b0;
    ovr0 = ovr_a;
    q_a.push_back('{data:32'h0F0F0F, right:1'b0, shrt:1'b0});
    add_slot(32, 32'h0F0F0F, 24, 1'b0);
    add_slot(32, 32'h777777, 24, 1'b1);
    add_slot(10, 32'h246802, 24, 1'b0);
    play(1'b1, -1, 32'h0);
    chk("pend_valid", 32'(rx_valid_a), 32'd1);
    chk("pend_ovr", 32'(ovr_a - ovr0), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_valid", 32'(rx_valid_a), 32'd0);
    chk("mid_rst_data", 32'(rx_data_a), 32'd0);
    chk("mid_rst_right", 32'(rx_right_a), 32'd0);
    chk("mid_rst_short", 32'(rx_short_a), 32'd0);
    chk("mid_rst_ovr", 32'(overrun_a), 32'd0);
    q_a.delete();
    rx_ready_a = 1'b1;
    q_a.push_back('{data:32'h13579B, right:1'b1, shrt:1'b0});
    add_slot(22, 32'h0, 0, 1'b0);
    add_slot(32, 32'h13579B, 24, 1'b1);
    add_slot(2, 32'h0, 0, 1'b0);
    play(1'b1, -1, 32'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
